// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-requester round-robin arbiter; registered one-hot + index grant; optional hold timeout via RR_TIMEOUT_EN
//   clk, rst (async active-high), req[7:0], done -> gnt[7:0], gnt_idx[2:0], gnt_valid, timeout
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [2:0] ptr;
  logic [2:0] sel;
  logic rel;
  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_arbiter8: illegal MAX_HOLD/CNT_W");
  end
  // descending scan so the smallest offset from ptr wins
  always_comb begin
    sel = ptr;
    for (int k = 7; k >= 0; k--)
      if (req[ptr + 3'(k)]) sel = ptr + 3'(k);
  end
  assign rel = done | ~req[gnt_idx];
`ifdef RR_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic expire;
  assign expire = hold_cnt == CNT_W'(MAX_HOLD - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt <= 8'h00;
      gnt_idx <= 3'd0;
      gnt_valid <= 1'b0;
      timeout <= 1'b0;
      ptr <= 3'd0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state <= GRANT;
          gnt_idx <= sel;
          gnt <= 8'(1) << sel;
          gnt_valid <= 1'b1;
          hold_cnt <= '0;
        end
      end else if (rel || expire) begin
        state <= IDLE;
        gnt <= 8'h00;
        gnt_valid <= 1'b0;
        ptr <= gnt_idx + 3'd1;
        timeout <= ~rel;
      end else begin
        hold_cnt <= hold_cnt + CNT_W'(hold_cnt != '1);
      end
    end
  end
`else
  assign timeout = 1'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt <= 8'h00;
      gnt_idx <= 3'd0;
      gnt_valid <= 1'b0;
      ptr <= 3'd0;
    end else if (state == IDLE) begin
      if (|req) begin
        state <= GRANT;
        gnt_idx <= sel;
        gnt <= 8'(1) << sel;
        gnt_valid <= 1'b1;
      end
    end else if (rel) begin
      state <= IDLE;
      gnt <= 8'h00;
      gnt_valid <= 1'b0;
      ptr <= gnt_idx + 3'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: vector table, corner sequences and randomized model check for rr_arbiter8
module tb_rr_arbiter8;
  localparam int MAX_HOLD = 4;
`ifdef RR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic gnt_valid;
  logic timeout;
  int n_cmp = 0;
  int n_bad = 0;
  int m_valid, m_idx, m_ptr, m_hold, m_to;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
  } vec_t;

  task automatic check(input string name, input logic [7:0] g, input logic [2:0] i,
                       input logic v, input logic t);
    n_cmp++;
    if (gnt !== g || gnt_idx !== i || gnt_valid !== v || timeout !== t) begin
      n_bad++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
               name, gnt, gnt_idx, gnt_valid, timeout, g, i, v, t);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
  endtask

  // spec rules in arithmetic form: scan offsets from ptr, release on done/drop/limit
  task automatic model_step(input logic [7:0] r, input logic d);
    m_to = 0;
    if (m_valid == 0) begin
      for (int off = 0; off < 8; off++)
        if (m_valid == 0 && r[(m_ptr + off) % 8]) begin
          m_valid = 1; m_idx = (m_ptr + off) % 8; m_hold = 0;
        end
    end else if (d || !r[m_idx]) begin
      m_valid = 0; m_ptr = (m_idx + 1) % 8;
    end else if (TO_EN && m_hold >= MAX_HOLD - 1) begin
      m_valid = 0; m_ptr = (m_idx + 1) % 8; m_to = 1;
    end else begin
      m_hold = (m_hold < 255) ? m_hold + 1 : 255;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic cyc(input logic [7:0] r, input logic d);
    req = r; done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[$];
    tbl = '{
      '{8'hFF, 1'b0, 8'h01, 3'd0, 1'b1}, '{8'hFF, 1'b1, 8'h00, 3'd0, 1'b0},
      '{8'hFF, 1'b0, 8'h02, 3'd1, 1'b1}, '{8'hFF, 1'b1, 8'h00, 3'd1, 1'b0},
      '{8'h05, 1'b0, 8'h04, 3'd2, 1'b1}, '{8'h05, 1'b1, 8'h00, 3'd2, 1'b0},
      '{8'h05, 1'b0, 8'h01, 3'd0, 1'b1}, '{8'h05, 1'b0, 8'h01, 3'd0, 1'b1},
      '{8'h04, 1'b0, 8'h00, 3'd0, 1'b0}, '{8'h04, 1'b1, 8'h04, 3'd2, 1'b1},
      '{8'h14, 1'b0, 8'h04, 3'd2, 1'b1}, '{8'h10, 1'b0, 8'h00, 3'd2, 1'b0},
      '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1}, '{8'h10, 1'b1, 8'h00, 3'd4, 1'b0},
      '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1}, '{8'h18, 1'b1, 8'h00, 3'd4, 1'b0},
      '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1}, '{8'h02, 1'b0, 8'h00, 3'd3, 1'b0},
      '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1}, '{8'h00, 1'b0, 8'h00, 3'd1, 1'b0},
      '{8'h00, 1'b0, 8'h00, 3'd1, 1'b0}
    };
    do_reset();
    check("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      cyc(tbl[i].req, tbl[i].done);
      check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].valid, 1'b0);
    end
    // full rotation with wrap
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(8'hFF, 1'b0);
      check($sformatf("rot_g%0d", i), 8'(1) << (i % 8), 3'(i % 8), 1'b1, 1'b0);
      cyc(8'hFF, 1'b1);
      check($sformatf("rot_b%0d", i), 8'h00, 3'(i % 8), 1'b0, 1'b0);
    end
    // async reset mid-grant
    cyc(8'hFF, 1'b0);
    check("pre_rst", 8'h02, 3'd1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cyc(8'hFF, 1'b0);
    check("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);
    // hold limit: req[2] held, no done
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      cyc(8'h04, 1'b0);
      if (TO_EN)
        check($sformatf("hold%0d", i), (i % 5 != 0) ? 8'h04 : 8'h00, 3'd2, i % 5 != 0, i % 5 == 0);
      else
        check($sformatf("hold%0d", i), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    // randomized against model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom) & 8'($urandom));
      cyc(r, $urandom_range(0, 3) == 0);
      check($sformatf("rand%0d", i), m_valid ? 8'(1) << m_idx : 8'h00, 3'(m_idx), m_valid != 0, m_to != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter sharing one resource slot.
- Grant is issued as a 3-bit index plus its one-hot 3-to-8 decode.
- Sits in front of the shared decoder-selected resource.
- The one-hot output drives the resource enables directly.
- A requester holds the grant until it signals done or drops its request.

Parameters:
- MAX_HOLD, 16: maximum grant length in cycles. Used only when RR_TIMEOUT_EN is defined. Legal range 1..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  8  request vector; bit i = requester i.
- done  input  1  current owner releases the grant. Sampled only in GRANT.
- gnt  output  8  one-hot grant. All zero when no grant is active.
- gnt_idx  output  3  binary index of the current/last grant.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  1-cycle pulse when a grant is force-released. Tied 0 without RR_TIMEOUT_EN.

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, ptr=3'd0, hold_cnt=0.
- All outputs are registered.
- gnt always equals the 3-to-8 decode of gnt_idx when gnt_valid=1, else 8'h00.
- ptr (internal, 3 bits) is the highest-priority index.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit scanning ptr, ptr+1, ..., ptr+7 modulo 8 (wrap 7->0).
  - Next edge: gnt_idx=sel, gnt_valid=1, gnt=onehot(sel), hold_cnt=0, state=GRANT.
  - Latency from req sampled high in IDLE to gnt high: 1 cycle.
- GRANT:
  - Release condition: done=1, or req[gnt_idx]=0.
  - On release, next edge: gnt_valid=0, gnt=0, ptr=gnt_idx+1 (mod 8), state=IDLE. gnt_idx keeps the last value.
  - Otherwise hold all outputs and increment hold_cnt (saturating).
  - done and a request drop in the same cycle count as a single release.
- Mandatory one-cycle IDLE bubble between consecutive grants, even if the same or other requests are pending.
- Back-to-back fairness:
  - A requester that just released has the lowest priority on the next arbitration.
  - A requester that is the sole requester is re-granted after the bubble.
- req changes on non-owner bits during GRANT are ignored.
- done asserted in IDLE is ignored.
- rst asserted mid-grant: gnt drops to 0 immediately (asynchronously) and ptr returns to 0.

Optional Feature:
- Macro: RR_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt reaches MAX_HOLD-1 with no release, force a release on the next edge, with the same effect as a done release.
  - Additionally pulse timeout=1 for exactly that one cycle (coincident with gnt_valid falling).
  - A normal release on the same cycle takes precedence, and timeout stays 0.
- Undefined:
  - No hold limit; hold_cnt logic is omitted.
  - timeout is constant 0.

Test Plan:
- Reset: assert rst with req=8'hFF mid-grant -> gnt=0, gnt_valid=0, gnt_idx=0 asynchronously. After release, first grant is gnt=8'h01.
- Rotation: req=8'hFF held, done pulsed each grant -> gnt sequence 01,02,04,...,80,01 (wraps). A 1-cycle gap follows each.
- Skip and wrap: ptr=6 (after granting 5), req=8'b0000_0101 -> gnt_idx=0 (gnt=8'h01), then gnt_idx=2.
- Request drop: owner 3 deasserts req[3] without done -> gnt_valid falls next cycle, ptr=4. Pending req[1] is granted after the bubble.
- Sole requester: req=8'h10 only, done pulses -> re-granted gnt=8'h10 after exactly one idle cycle. Non-owner req toggles during GRANT do not change gnt.
- Timeout (RR_TIMEOUT_EN, MAX_HOLD=4): req[2] held, done=0 -> gnt=8'h04 for 4 cycles, timeout pulses once as gnt drops, then 8'h04 is re-granted after the bubble. Without the macro, the grant holds indefinitely and timeout=0.
